counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
Sequencing controller for the 3-bit T-flip-flop custom-sequence counter datapath. Turns raw pushbutton and switch inputs into clean single-cycle load and step strobes, and supports single-step, free-run and stop-on-match operation. Keeps an 8-bit step tally for the BCD/7-segment display path. Sits between the board I/O (KEY/SW) and the counter datapath, which feeds its Q back into this block.

Parameters:
TICK_DIV, 50000000, clk cycles between free-run steps (1 Hz at 50 MHz); minimum 2
DEB_CYCLES, 500000, cycles a synchronized key level must be stable before it is accepted; minimum 1

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-high reset
key_load_n  input  1  pushbutton, active-low, asynchronous to clk: load request
key_step_n  input  1  pushbutton, active-low, asynchronous: single step
key_run_n  input  1  pushbutton, active-low, asynchronous: toggle free-run
sw_load_val  input  3  value loaded into the counter
sw_stop_val  input  3  stop-on-match target
sw_stop_en  input  1  1 = halt free-run when counter equals sw_stop_val
cnt_q  input  3  current counter datapath output (feedback)
cnt_load  output  1  one-cycle load strobe to datapath
cnt_load_val  output  3  data presented with cnt_load
cnt_step  output  1  one-cycle step enable to datapath
steps  output  8  steps issued since last load; saturates at 255
running  output  1  1 while in RUN
match  output  1  1 while in HALT due to stop match
state  output  2  encoded FSM state for LEDG debug

Behaviour:
- Reset (sync, active-high): state=IDLE; all outputs 0; debouncers, prescaler and pending flag cleared. Reset mid-RUN aborts on that edge; no strobe is emitted in the reset cycle.
- Keys: 2-flop synchronizer, then debounce. The accepted level changes only after DEB_CYCLES consecutive equal samples. A press event is a 1-cycle pulse on the accepted 1→0 transition. Holding a key produces exactly one event.
- FSM states: IDLE=0, LOAD=1, RUN=2, HALT=3.
- Event priority within one cycle: load > run > step.
- IDLE: load event → LOAD. run event → RUN. step event → cnt_step=1 for one cycle, steps+=1, stay IDLE.
- LOAD: lasts exactly 1 cycle. Assert cnt_load=1 and cnt_load_val=sw_load_val, which is sampled in this cycle. Clear steps and match, reset the prescaler, then go to IDLE. cnt_load_val holds its value afterwards.
- RUN: running=1. Prescaler counts 0..TICK_DIV-1. On terminal count: cnt_step=1, steps+=1, set step_pending.
  - In the cycle after a step, cnt_q reflects the new value. If step_pending, sw_stop_en=1 and cnt_q==sw_stop_val: go to HALT, set match=1. Clear step_pending in all cases.
  - run event → IDLE, prescaler cleared.
  - load event → LOAD.
  - step events are ignored.
  - Match is checked only after a step, never on entry, so starting while already at the target runs at least one step.
- HALT: running=0, match=1. run event → RUN (match cleared). load event → LOAD. step event → single step, cnt_step=1, stay HALT.
- steps saturates at 8'd255 and never wraps. A load is the only thing that clears it.
- cnt_step and cnt_load are never high in the same cycle, and neither is ever high for two consecutive cycles.
- Latency:
  - key physical press to event: 2 + DEB_CYCLES cycles.
  - event to strobe: 1 cycle (registered outputs).

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_LOAD, ST_RUN, ST_HALT) and default TICK_DIV/DEB_CYCLES constants, reused by the top-level and bench.
- One natural sub-module: key_debounce (synchronizer + stable counter + press-pulse), instantiated three times.

Test Plan:
(All with TICK_DIV=4, DEB_CYCLES=2.)
1. Reset, then hold key_load_n=0 with sw_load_val=3'b101 → exactly one cnt_load pulse with cnt_load_val=5; steps=0; state back to IDLE one cycle later.
2. Three separate step presses in IDLE → three single-cycle cnt_step pulses, steps=3; holding a key 20 cycles yields only one pulse.
3. Run press, stop_en=0 → cnt_step every 4th cycle, running=1; second run press → IDLE, no further strobes.
4. Run with stop_en=1, sw_stop_val=3; bench model steps cnt_q 0→1→2→3 → HALT entered the cycle after cnt_q becomes 3, match=1, running=0, steps=3.
5. Load and run pressed in the same accepted cycle → LOAD wins, one cnt_load, no RUN entry; 256+ single steps → steps stays 255.
6. Assert reset mid-RUN at the cycle a step would fire → no cnt_step that cycle; all outputs 0, state=IDLE.

Source files
------------

// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the counter run controller: FSM encodings,
// default timing constants and the saturating step-tally helper.
package counter_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    localparam int DEF_TICK_DIV   = 50000000;
    localparam int DEF_DEB_CYCLES = 500000;

    localparam logic [7:0] STEPS_MAX = 8'd255;

    // Step tally increment that sticks at the top instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == STEPS_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/counter_run_ctrl_key_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stable-level debounce and a
// single-cycle press pulse on each accepted released-to-pressed transition.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous key into the clk domain; idle level is released (1).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync2;
                stable_cnt <= '0;
                press      <= ~sync2;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Sequencing controller for the 3-bit custom-sequence counter: debounces the
// board keys and issues load/step strobes for single-step, free-run and
// stop-on-match operation, keeping a saturating tally of issued steps.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_load_n,
    input  logic       key_step_n,
    input  logic       key_run_n,
    input  logic [2:0] sw_load_val,
    input  logic [2:0] sw_stop_val,
    input  logic       sw_stop_en,
    input  logic [2:0] cnt_q,
    output logic       cnt_load,
    output logic [2:0] cnt_load_val,
    output logic       cnt_step,
    output logic [7:0] steps,
    output logic       running,
    output logic       match,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          load_ev;
    logic          run_ev;
    logic          step_ev;

    run_state_t    state_q;
    run_state_t    state_d;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic          step_pending;
    logic          pending_d;
    logic          load_d;
    logic          step_d;
    logic [2:0]    load_val_d;
    logic [7:0]    steps_d;
    logic          tick;
    logic          stop_hit;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk   (clk),
        .reset (reset),
        .key_n (key_load_n),
        .press (load_ev)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .reset (reset),
        .key_n (key_run_n),
        .press (run_ev)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .reset (reset),
        .key_n (key_step_n),
        .press (step_ev)
    );

    // step_pending is raised the cycle after a free-run strobe, which is when
    // the datapath's cnt_q first shows the stepped value.
    assign tick     = (presc == PRESC_LAST);
    assign stop_hit = step_pending && sw_stop_en && (cnt_q == sw_stop_val);
    assign state    = state_q;

    // Next-state and next-output decode; load beats run beats step.
    always_comb begin
        state_d    = state_q;
        load_d     = 1'b0;
        step_d     = 1'b0;
        load_val_d = cnt_load_val;
        steps_d    = steps;
        presc_d    = '0;
        pending_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_ev) begin
                    state_d = ST_LOAD;
                end else if (run_ev) begin
                    state_d = ST_RUN;
                end else if (step_ev) begin
                    step_d = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (load_ev) begin
                    state_d = ST_LOAD;
                end else if (run_ev) begin
                    state_d = ST_IDLE;
                end else if (stop_hit) begin
                    state_d = ST_HALT;
                end else begin
                    pending_d = cnt_step;
                    if (tick) begin
                        step_d = 1'b1;
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                end
            end
            ST_HALT: begin
                if (load_ev) begin
                    state_d = ST_LOAD;
                end else if (run_ev) begin
                    state_d = ST_RUN;
                end else if (step_ev) begin
                    step_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_LOAD) begin
            load_d     = 1'b1;
            load_val_d = sw_load_val;
            steps_d    = '0;
        end

        if (step_d) begin
            steps_d = sat_inc(steps);
        end
    end

    // State register and registered outputs, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc        <= '0;
            step_pending <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_step     <= 1'b0;
            steps        <= '0;
            running      <= 1'b0;
            match        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc        <= presc_d;
            step_pending <= pending_d;
            cnt_load     <= load_d;
            cnt_load_val <= load_val_d;
            cnt_step     <= step_d;
            steps        <= steps_d;
            running      <= (state_d == ST_RUN);
            match        <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl with a small datapath stand-in,
// a cycle-level behavioural model and directed plus randomized key activity.
module tb_counter_run_ctrl;
    import counter_run_ctrl_pkg::*;

    localparam int TB_TICK = 4;
    localparam int TB_DEB  = 2;
    localparam int MAXCYC  = 60000;

    logic       clk;
    logic       reset;
    logic       key_load_n;
    logic       key_step_n;
    logic       key_run_n;
    logic [2:0] sw_load_val;
    logic [2:0] sw_stop_val;
    logic       sw_stop_en;
    logic [2:0] cnt_q;
    logic       cnt_load;
    logic [2:0] cnt_load_val;
    logic       cnt_step;
    logic [7:0] steps;
    logic       running;
    logic       match;
    logic [1:0] state;

    int checks;
    int failures;
    int cyc;
    int load_pulses;
    int step_pulses;
    bit model_valid;
    bit [2:0] ev_sched [0:MAXCYC-1];

    int         m_state;
    int         m_run_age;
    int         m_last_run_step;
    logic       m_load;
    logic       m_step;
    logic [2:0] m_load_val;
    logic [7:0] m_steps;

    counter_run_ctrl #(.TICK_DIV(TB_TICK), .DEB_CYCLES(TB_DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_load_n   (key_load_n),
        .key_step_n   (key_step_n),
        .key_run_n    (key_run_n),
        .sw_load_val  (sw_load_val),
        .sw_stop_val  (sw_stop_val),
        .sw_stop_en   (sw_stop_en),
        .cnt_q        (cnt_q),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_step     (cnt_step),
        .steps        (steps),
        .running      (running),
        .match        (match),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath stand-in: loads on cnt_load, increments on cnt_step.
    always @(posedge clk) begin
        if (reset)         cnt_q <= 3'd0;
        else if (cnt_load) cnt_q <= cnt_load_val;
        else if (cnt_step) cnt_q <= cnt_q + 3'd1;
    end

    // Behavioural model: one update per clock edge from the scheduled key events.
    initial begin
        cyc = 0; load_pulses = 0; step_pulses = 0; model_valid = 1'b0;
        m_state = 0; m_run_age = 0; m_last_run_step = -100;
        m_load = 1'b0; m_step = 1'b0; m_load_val = 3'd0; m_steps = 8'd0;
        forever begin
            int nxt;
            bit do_step;
            logic [2:0] ev;
            @(posedge clk);
            cyc = cyc + 1;
            load_pulses = load_pulses + int'(cnt_load);
            step_pulses = step_pulses + int'(cnt_step);
            ev = (cyc < MAXCYC) ? ev_sched[cyc] : 3'b000;
            if (reset) begin
                m_state = 0; m_run_age = 0; m_last_run_step = -100;
                m_load = 1'b0; m_step = 1'b0; m_load_val = 3'd0; m_steps = 8'd0;
                model_valid = 1'b1;
            end else begin
                nxt = m_state;
                do_step = 1'b0;
                if (m_state == 0) begin
                    if (ev[0]) nxt = 1;
                    else if (ev[1]) nxt = 2;
                    else if (ev[2]) do_step = 1'b1;
                end else if (m_state == 1) begin
                    nxt = 0;
                end else if (m_state == 2) begin
                    if (ev[0]) nxt = 1;
                    else if (ev[1]) nxt = 0;
                    else if (cyc == m_last_run_step + 2 && sw_stop_en && cnt_q == sw_stop_val) nxt = 3;
                    else begin
                        m_run_age = m_run_age + 1;
                        if (m_run_age % TB_TICK == 0) begin
                            do_step = 1'b1;
                            m_last_run_step = cyc;
                        end
                    end
                end else begin
                    if (ev[0]) nxt = 1;
                    else if (ev[1]) nxt = 2;
                    else if (ev[2]) do_step = 1'b1;
                end
                if (nxt == 2 && m_state != 2) m_run_age = 0;
                m_load = 1'b0;
                m_step = do_step;
                if (nxt == 1) begin
                    m_load = 1'b1;
                    m_load_val = sw_load_val;
                    m_steps = 8'd0;
                end
                if (do_step && m_steps != 8'd255) m_steps = m_steps + 8'd1;
                m_state = nxt;
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus strobe rules.
    initial begin
        logic prev_load;
        logic prev_step;
        logic [16:0] act_vec;
        logic [16:0] exp_vec;
        prev_load = 1'b0;
        prev_step = 1'b0;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                act_vec = {state, running, match, cnt_load, cnt_step, steps, cnt_load_val};
                exp_vec = {2'(m_state), (m_state == 2), (m_state == 3), m_load, m_step, m_steps, m_load_val};
                checks = checks + 1;
                if (act_vec !== exp_vec) begin
                    failures = failures + 1;
                    $display("[TB] FAIL outputs cyc=%0d actual st/run/mt/ld/stp/steps/val=%0d/%0b/%0b/%0b/%0b/%0d/%0d required=%0d/%0b/%0b/%0b/%0b/%0d/%0d",
                             cyc, state, running, match, cnt_load, cnt_step, steps, cnt_load_val,
                             m_state, (m_state == 2), (m_state == 3), m_load, m_step, m_steps, m_load_val);
                end
                checks = checks + 1;
                if ((cnt_load && cnt_step) || (cnt_load && prev_load) || (cnt_step && prev_step)) begin
                    failures = failures + 1;
                    $display("[TB] FAIL strobe_rule cyc=%0d actual load=%0b step=%0b prev_load=%0b prev_step=%0b required single isolated strobes",
                             cyc, cnt_load, cnt_step, prev_load, prev_step);
                end
                prev_load = cnt_load;
                prev_step = cnt_step;
            end
        end
    end

    // Time limit so the bench always reaches its summary.
    initial begin
        #(50000 * 10);
        failures = failures + 1;
        $display("[TB] FAIL watchdog: time limit expired at cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: actual %0d required %0d (cyc=%0d)", name, actual, expected, cyc);
        end
    endtask

    // Press the keys in mask (bit0 load, bit1 run, bit2 step) for hold cycles, then release.
    task automatic applyStimulus(input logic [2:0] mask, input int hold, input int gap);
        int at;
        at = cyc + 3 + TB_DEB;
        if (mask[0]) key_load_n = 1'b0;
        if (mask[1]) key_run_n  = 1'b0;
        if (mask[2]) key_step_n = 1'b0;
        if (hold >= TB_DEB && at < MAXCYC) ev_sched[at] = ev_sched[at] | mask;
        repeat (hold) @(negedge clk);
        key_load_n = 1'b1;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int n0;
        int base_load;
        int base_step;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        key_load_n = 1'b1;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        sw_load_val = 3'd0;
        sw_stop_val = 3'd0;
        sw_stop_en  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_state", state, 0);
        checkOutput("reset_steps", steps, 0);
        checkOutput("reset_strobes", {cnt_load, cnt_step, running, match}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] held load key with value 5");
        sw_load_val = 3'b101;
        base_load = load_pulses;
        applyStimulus(3'b001, 10, 4);
        checkOutput("load_pulse_count", load_pulses - base_load, 1);
        checkOutput("load_value", cnt_load_val, 5);
        checkOutput("load_steps", steps, 0);
        checkOutput("load_back_idle", state, int'(ST_IDLE));

        $display("[TB] single steps in IDLE");
        base_step = step_pulses;
        for (int i = 0; i < 3; i++) applyStimulus(3'b100, 3, 5);
        checkOutput("three_steps_pulses", step_pulses - base_step, 3);
        checkOutput("three_steps_tally", steps, 3);
        base_step = step_pulses;
        applyStimulus(3'b100, 20, 5);
        checkOutput("held_step_pulses", step_pulses - base_step, 1);
        checkOutput("held_step_tally", steps, 4);

        $display("[TB] free run without stop");
        sw_stop_en = 1'b0;
        applyStimulus(3'b010, 2, 4);
        base_step = step_pulses;
        repeat (16) @(negedge clk);
        checkOutput("run_step_rate", step_pulses - base_step, 4);
        checkOutput("run_running", running, 1);
        applyStimulus(3'b010, 2, 4);
        base_step = step_pulses;
        repeat (12) @(negedge clk);
        checkOutput("stop_no_steps", step_pulses - base_step, 0);
        checkOutput("stop_idle", state, int'(ST_IDLE));

        $display("[TB] run until counter reaches 3");
        sw_load_val = 3'd0;
        applyStimulus(3'b001, 2, 4);
        sw_stop_val = 3'd3;
        sw_stop_en  = 1'b1;
        applyStimulus(3'b010, 2, 4);
        repeat (20) @(negedge clk);
        checkOutput("halt_state", state, int'(ST_HALT));
        checkOutput("halt_match", match, 1);
        checkOutput("halt_running", running, 0);
        checkOutput("halt_steps", steps, 3);
        checkOutput("halt_cnt_q", cnt_q, 3);

        $display("[TB] start while already at target");
        sw_load_val = 3'd3;
        applyStimulus(3'b001, 2, 4);
        applyStimulus(3'b010, 2, 4);
        repeat (6) @(negedge clk);
        checkOutput("entry_no_halt", state, int'(ST_RUN));
        checkOutput("entry_first_step", steps, 1);
        repeat (40) @(negedge clk);
        checkOutput("wrap_halt_state", state, int'(ST_HALT));
        checkOutput("wrap_halt_steps", steps, 8);

        $display("[TB] load and run together, then saturate tally");
        sw_stop_en  = 1'b0;
        sw_load_val = 3'd2;
        base_load = load_pulses;
        applyStimulus(3'b011, 3, 6);
        checkOutput("priority_load_pulses", load_pulses - base_load, 1);
        checkOutput("priority_idle", state, int'(ST_IDLE));
        checkOutput("priority_not_running", running, 0);
        for (int i = 0; i < 260; i++) applyStimulus(3'b100, 2, 4);
        checkOutput("steps_saturate", steps, 255);

        $display("[TB] reset during free run");
        sw_load_val = 3'd0;
        applyStimulus(3'b001, 2, 4);
        n0 = cyc;
        applyStimulus(3'b010, 2, 4);
        waitUntil(n0 + 12);
        checkOutput("pre_reset_steps", steps, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_step", cnt_step, 0);
        checkOutput("midrun_reset_state", state, int'(ST_IDLE));
        checkOutput("midrun_reset_outputs", {cnt_load, running, match, steps, cnt_load_val}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] randomized key activity");
        for (int i = 0; i < 150; i++) begin
            int act;
            int hold;
            int gap;
            act  = int'($urandom_range(0, 10));
            hold = int'($urandom_range(TB_DEB, TB_DEB + 6));
            gap  = int'($urandom_range(TB_DEB + 2, TB_DEB + 12));
            sw_load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) sw_stop_val = 3'($urandom_range(0, 7));
            sw_stop_en = 1'($urandom_range(0, 1));
            case (act)
                0, 1:    applyStimulus(3'b001, hold, gap);
                2, 3:    applyStimulus(3'b010, hold, gap);
                4, 5, 6: applyStimulus(3'b100, hold, gap);
                7:       applyStimulus(3'($urandom_range(1, 7)), hold, gap);
                8:       applyStimulus(3'($urandom_range(1, 7)), 1, gap);
                9: begin
                    reset = 1'b1;
                    repeat (2) @(negedge clk);
                    reset = 1'b0;
                    repeat (2) @(negedge clk);
                end
                default: repeat ($urandom_range(1, 12)) @(negedge clk);
            endcase
        end
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
